bfm_apbslave: RTL and testbench
===============================

BFM_APBSLAVE -- requirements
Module: bfm_apbslave

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 256: number of 32-bit memory words; legal range 1..1024.
REQ-002 The block SHALL have parameter INIT_ZERO, default 1: 1 = memory cleared to 0 at time zero; 0 = memory holds X at time zero.
REQ-003 The block SHALL have port PCLK, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port PRESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port PSEL, input, 1 bit: slave select.
REQ-006 The block SHALL have port PENABLE, input, 1 bit: access-phase strobe.
REQ-007 The block SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port PADDR, input, 32 bits: byte address.
REQ-009 The block SHALL have port PWDATA, input, 32 bits: write data.
REQ-010 The block SHALL have port WAITS, input, 4 bits: wait states inserted per transfer; sampled in the setup phase.
REQ-011 The block SHALL have port PRDATA, output, 32 bits: read data.
REQ-012 The block SHALL have port PREADY, output, 1 bit: transfer completes this cycle.
REQ-013 The block SHALL have port PSLVERR, output, 1 bit: error response; valid only while PREADY=1.
REQ-014 The block SHALL have port PROT_ERR, output, 1 bit: sticky flag for an APB protocol violation by the initiator.
REQ-015 The block SHALL have port XFER_CNT, output, 16 bits: count of completed transfers, wrapping.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, ACCESS and ABORT; every output SHALL be driven from registers.
REQ-017 IDLE, PSEL=1 and PENABLE=0 (setup phase): the block SHALL capture PADDR, PWRITE, PWDATA and WAITS, load WCNT=WAITS, set PREADY<=(WAITS==0), and go to ACCESS.
REQ-018 Error decode at setup: error=1 when PADDR[1:0]!=0 or PADDR[31:2]>=MEM_WORDS; PSLVERR<=error.
REQ-019 Read at setup: PRDATA SHALL be loaded with mem[PADDR[11:2]] when there is no error, else 32'h0000_0000.
REQ-020 ACCESS with PREADY=0: WCNT SHALL decrement each cycle, and PREADY SHALL be set to 1 on the cycle after WCNT reaches 1. Total access-phase length is WAITS+1 cycles.
REQ-021 Completion edge is PSEL=1, PENABLE=1, PREADY=1. At this edge:
- write with no error: mem SHALL be written with PWDATA as captured at setup;
- error: the write SHALL be suppressed;
- XFER_CNT SHALL increment, wrapping 16'hFFFF to 16'h0000;
- PREADY, PSLVERR and PRDATA SHALL clear to 0;
- the state SHALL go to IDLE.
REQ-022 Back-to-back transfers: a setup phase in the cycle right after completion SHALL be accepted with no idle gap.
REQ-023 ACCESS with PSEL=0 before completion: the transfer SHALL be aborted with no write and no XFER_CNT increment; PROT_ERR SHALL be set; PREADY and PSLVERR SHALL clear; the state SHALL go to ABORT.
REQ-024 ACCESS with PSEL=1, PENABLE=0 (new setup before completion): this SHALL be treated as an abort (per REQ-023), and the block SHALL return to IDLE on the following cycle.
REQ-025 ABORT SHALL last exactly one cycle, then go to IDLE. A setup phase seen during ABORT SHALL be ignored.
REQ-026 IDLE with PENABLE=1 and PSEL=1 (access without setup): PROT_ERR SHALL be set; there is no response and the state does not change.
REQ-027 PROT_ERR SHALL be sticky; only reset clears it.
REQ-028 A change in PADDR, PWRITE, PWDATA or WAITS during ACCESS SHALL have no effect, because the captured values are used.

Reset
REQ-029 PRESETN=0 SHALL immediately force the following, regardless of PCLK: state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, PROT_ERR=0, XFER_CNT=0, WCNT=0.
REQ-030 Memory contents SHALL NOT be altered by reset.
REQ-031 Reset asserted mid-transfer SHALL discard the transfer with no memory write.
REQ-032 The first setup phase accepted SHALL be the one sampled on the first PCLK edge after PRESETN rises.

Verification
REQ-033 Write then read, zero wait states. Stimulus: WAITS=0; write 0xDEADBEEF to address 0x10; read address 0x10. Response: each access phase is 1 cycle with PREADY=1; PRDATA=0xDEADBEEF; PSLVERR=0; XFER_CNT=2.
REQ-034 Wait states. Stimulus: WAITS=3; read address 0x0. Response: PREADY is low for 3 access cycles and high on the 4th; XFER_CNT increments once.
REQ-035 Error responses. Stimulus: MEM_WORDS=256; write to address 0x400; read address 0x2. Response: both have PSLVERR=1 with PREADY=1; no memory change; the read returns PRDATA=0.
REQ-036 Abort. Stimulus: WAITS=5; drop PSEL in the 2nd access cycle of a write. Response: no write; PROT_ERR=1; XFER_CNT unchanged; the next transfer completes normally.
REQ-037 Counter wrap and reset. Stimulus: drive XFER_CNT to 0xFFFF with one more transfer; later assert PRESETN mid-wait. Response: XFER_CNT reads 0x0000 after the wrap; after reset all outputs are 0 immediately and memory contents are preserved.

Source files
------------

// File: rtl/bfm_apbslave.sv
// APB slave bus-functional model backed by a word-addressed memory.
// Accepts setup/access transfers with a programmable number of wait states,
// flags out-of-range or misaligned accesses with PSLVERR, counts completed
// transfers and records initiator protocol violations in a sticky flag.
// All outputs come straight from registers.

module bfm_apbslave #(
    parameter int MEM_WORDS = 256,
    parameter int INIT_ZERO = 1
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  WAITS,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PROT_ERR,
    output logic [15:0] XFER_CNT
);

    // Word-index width; a single-word memory still needs one index bit.
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ABORT  = 2'd2
    } state_t;

    state_t          state_reg;
    logic [3:0]      wcnt_reg;
    logic            wr_reg;
    logic            err_reg;
    logic [AW-1:0]   idx_reg;
    logic [31:0]     wdata_reg;

    logic            setup_err;
    logic [AW-1:0]   rd_idx;
    logic [31:0]     mem_rd;
    logic            complete;
    logic            mem_we;

    // Address decode for the transfer being set up right now.
    assign setup_err = (PADDR[1:0] != 2'b00) || (PADDR[31:2] >= 30'(MEM_WORDS));
    assign rd_idx    = PADDR[AW+1:2];

    // A transfer finishes on the edge where the initiator holds the access
    // phase and we already present PREADY.
    assign complete  = (state_reg == ST_ACCESS) && PSEL && PENABLE && PREADY;

    // Only error-free writes reach the array, using the values captured at
    // setup so the initiator may change the bus during the access phase.
    assign mem_we    = complete && wr_reg && !err_reg;

    generate
        if (INIT_ZERO != 0) begin : g_mem_zero
            logic [31:0] mem [MEM_WORDS] = '{default: 32'h0000_0000};

            // Memory write port; deliberately outside the reset domain so
            // contents survive reset.
            always_ff @(posedge PCLK) begin
                if (mem_we) begin
                    mem[idx_reg] <= wdata_reg;
                end
            end

            assign mem_rd = mem[rd_idx];
        end else begin : g_mem_x
            logic [31:0] mem [MEM_WORDS];

            // Memory write port; deliberately outside the reset domain so
            // contents survive reset.
            always_ff @(posedge PCLK) begin
                if (mem_we) begin
                    mem[idx_reg] <= wdata_reg;
                end
            end

            assign mem_rd = mem[rd_idx];
        end
    endgenerate

    // Transfer state machine with registered response outputs.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_reg <= ST_IDLE;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= 32'h0000_0000;
            PROT_ERR  <= 1'b0;
            XFER_CNT  <= 16'h0000;
            wcnt_reg  <= 4'd0;
            wr_reg    <= 1'b0;
            err_reg   <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= 32'h0000_0000;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        // Setup phase: latch the whole request and prepare
                        // the response so it is valid in the first access cycle.
                        wr_reg    <= PWRITE;
                        err_reg   <= setup_err;
                        idx_reg   <= rd_idx;
                        wdata_reg <= PWDATA;
                        wcnt_reg  <= WAITS;
                        PREADY    <= (WAITS == 4'd0);
                        PSLVERR   <= setup_err;
                        PRDATA    <= (!PWRITE && !setup_err) ? mem_rd : 32'h0000_0000;
                        state_reg <= ST_ACCESS;
                    end else if (PSEL && PENABLE) begin
                        // Access phase without a preceding setup.
                        PROT_ERR <= 1'b1;
                    end
                end

                ST_ACCESS: begin
                    if (!PSEL || !PENABLE) begin
                        // Initiator left the access phase early: drop the
                        // transfer without writing or counting it.
                        PROT_ERR  <= 1'b1;
                        PREADY    <= 1'b0;
                        PSLVERR   <= 1'b0;
                        PRDATA    <= 32'h0000_0000;
                        state_reg <= ST_ABORT;
                    end else if (PREADY) begin
                        XFER_CNT  <= XFER_CNT + 16'd1;
                        PREADY    <= 1'b0;
                        PSLVERR   <= 1'b0;
                        PRDATA    <= 32'h0000_0000;
                        state_reg <= ST_IDLE;
                    end else begin
                        // Wait states: PREADY rises the cycle after the
                        // counter has reached one.
                        wcnt_reg <= wcnt_reg - 4'd1;
                        if (wcnt_reg <= 4'd1) begin
                            PREADY <= 1'b1;
                        end
                    end
                end

                ST_ABORT: begin
                    // One dead cycle; any setup seen here is ignored.
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bfm_apbslave.sv
// Directed testbench for bfm_apbslave: each task exercises one feature and
// compares the DUT outputs against hand-computed values.

module tb_bfm_apbslave;

    logic        PCLK    = 1'b0;
    logic        PRESETN = 1'b1;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [31:0] PADDR   = 32'h0;
    logic [31:0] PWDATA  = 32'h0;
    logic [3:0]  WAITS   = 4'h0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        PROT_ERR;
    logic [15:0] XFER_CNT;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [15:0] exp_cnt = 16'h0;

    bfm_apbslave #(
        .MEM_WORDS (256),
        .INIT_ZERO (1)
    ) dut (
        .PCLK     (PCLK),
        .PRESETN  (PRESETN),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .WAITS    (WAITS),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .PROT_ERR (PROT_ERR),
        .XFER_CNT (XFER_CNT)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Drives one complete transfer starting 1 time unit after a clock edge.
    // Returns the response sampled in the PREADY cycle and the access-phase
    // length; ends 1 time unit after the completion edge with the bus idle.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] waits, output logic [31:0] rdata,
                            output logic slverr, output int acc);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wdata;
        WAITS   = waits;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        acc = 1;
        while (PREADY !== 1'b1 && acc < 40) begin
            @(posedge PCLK); #1;
            acc++;
        end
        rdata  = PRDATA;
        slverr = PSLVERR;
        @(posedge PCLK); #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        $display("xfer wr=%0d addr=%h wdata=%h waits=%0d -> rdata=%h slverr=%0d acc=%0d cnt=%h",
                 wr, addr, wdata, waits, rdata, slverr, acc, XFER_CNT);
    endtask

    task automatic test_reset();
        PRESETN = 1'b1;
        #2;
        PRESETN = 1'b0;
        #1;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", PREADY); end
        checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", PSLVERR); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h want 0", PRDATA); end
        checks++; if (PROT_ERR !== 1'b0) begin errors++; $display("FAIL reset_prot_err: got %b want 0", PROT_ERR); end
        checks++; if (XFER_CNT !== 16'h0) begin errors++; $display("FAIL reset_xfer_cnt: got %h want 0", XFER_CNT); end
        repeat (2) @(posedge PCLK);
        #1;
        PRESETN = 1'b1;
        exp_cnt = 16'h0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        se;
        int          acc;
        apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (acc != 1) begin errors++; $display("FAIL wr0_len: got %0d want 1", acc); end
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL wr0_slverr: got %b want 0", se); end
        apb_xfer(1'b0, 32'h10, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (acc != 1) begin errors++; $display("FAIL rd0_len: got %0d want 1", acc); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd0_data: got %h want deadbeef", rd); end
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL rd0_slverr: got %b want 0", se); end
        checks++; if (XFER_CNT !== 16'd2) begin errors++; $display("FAIL wr_rd_cnt: got %h want 0002", XFER_CNT); end
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL post_done_pready: got %b want 0", PREADY); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL post_done_prdata: got %h want 0", PRDATA); end
        // Untouched word reads as zero at start-up.
        apb_xfer(1'b0, 32'h20, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL init_zero: got %h want 0", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic        se;
        int          acc;
        apb_xfer(1'b0, 32'h0, 32'h0, 4'd3, rd, se, acc);
        exp_cnt++;
        checks++; if (acc != 4) begin errors++; $display("FAIL wait3_len: got %0d want 4", acc); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wait3_data: got %h want 0", rd); end
        checks++; if (XFER_CNT !== exp_cnt) begin errors++; $display("FAIL wait3_cnt: got %h want %h", XFER_CNT, exp_cnt); end
    endtask

    task automatic test_capture();
        logic [31:0] rd;
        logic        se;
        int          acc;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'h8; PWDATA = 32'h11111111; WAITS = 4'd2;
        @(posedge PCLK); #1;
        // Scramble the request during the access phase.
        PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'hC; PWDATA = 32'h22222222; WAITS = 4'd0;
        acc = 1;
        while (PREADY !== 1'b1 && acc < 40) begin
            @(posedge PCLK); #1;
            acc++;
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        exp_cnt++;
        $display("xfer capture write addr=00000008 acc=%0d cnt=%h", acc, XFER_CNT);
        checks++; if (acc != 3) begin errors++; $display("FAIL capture_len: got %0d want 3", acc); end
        apb_xfer(1'b0, 32'h8, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL capture_data: got %h want 11111111", rd); end
        apb_xfer(1'b0, 32'hC, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL capture_other: got %h want 0", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        se;
        int          acc;
        apb_xfer(1'b1, 32'h0, 32'h12345678, 4'd0, rd, se, acc);
        exp_cnt++;
        apb_xfer(1'b1, 32'h400, 32'hA5A5A5A5, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (se !== 1'b1) begin errors++; $display("FAIL err_wr_slverr: got %b want 1", se); end
        checks++; if (acc != 1) begin errors++; $display("FAIL err_wr_len: got %0d want 1", acc); end
        apb_xfer(1'b0, 32'h0, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL err_wr_suppressed: got %h want 12345678", rd); end
        apb_xfer(1'b0, 32'h2, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (se !== 1'b1) begin errors++; $display("FAIL err_rd_slverr: got %b want 1", se); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rd_data: got %h want 0", rd); end
        apb_xfer(1'b0, 32'h3FC, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (se !== 1'b0) begin errors++; $display("FAIL last_word_slverr: got %b want 0", se); end
        checks++; if (XFER_CNT !== exp_cnt) begin errors++; $display("FAIL err_cnt: got %h want %h", XFER_CNT, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        se;
        int          acc;
        int          start;
        start = cyc;
        apb_xfer(1'b1, 32'h20, 32'hA0000001, 4'd0, rd, se, acc);
        apb_xfer(1'b1, 32'h24, 32'hA0000002, 4'd0, rd, se, acc);
        apb_xfer(1'b1, 32'h28, 32'hA0000003, 4'd0, rd, se, acc);
        exp_cnt = exp_cnt + 16'd3;
        checks++; if (cyc - start != 6) begin errors++; $display("FAIL b2b_cycles: got %0d want 6", cyc - start); end
        checks++; if (XFER_CNT !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %h want %h", XFER_CNT, exp_cnt); end
        apb_xfer(1'b0, 32'h24, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (rd !== 32'hA0000002) begin errors++; $display("FAIL b2b_data: got %h want a0000002", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        logic        se;
        int          acc;
        force dut.XFER_CNT = 16'hFFFF;
        #1;
        release dut.XFER_CNT;
        apb_xfer(1'b0, 32'h4, 32'h0, 4'd0, rd, se, acc);
        exp_cnt = 16'h0;
        checks++; if (XFER_CNT !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %h want 0000", XFER_CNT); end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic        se;
        int          acc;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'h14; PWDATA = 32'hCAFEF00D; WAITS = 4'd5;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        // Second access cycle: initiator drops PSEL.
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        $display("xfer abort write addr=00000014 prot_err=%0d cnt=%h", PROT_ERR, XFER_CNT);
        checks++; if (PROT_ERR !== 1'b1) begin errors++; $display("FAIL abort_prot_err: got %b want 1", PROT_ERR); end
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL abort_pready: got %b want 0", PREADY); end
        checks++; if (XFER_CNT !== exp_cnt) begin errors++; $display("FAIL abort_cnt: got %h want %h", XFER_CNT, exp_cnt); end
        // Setup presented during the abort cycle must be ignored.
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h14; WAITS = 4'd0;
        @(posedge PCLK); #1;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL abort_setup_ignored: got %b want 0", PREADY); end
        PSEL = 1'b0;
        @(posedge PCLK); #1;
        apb_xfer(1'b0, 32'h14, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_no_write: got %h want 0", rd); end
        checks++; if (acc != 1) begin errors++; $display("FAIL abort_next_len: got %0d want 1", acc); end
        checks++; if (XFER_CNT !== exp_cnt) begin errors++; $display("FAIL abort_next_cnt: got %h want %h", XFER_CNT, exp_cnt); end
        checks++; if (PROT_ERR !== 1'b1) begin errors++; $display("FAIL prot_err_sticky: got %b want 1", PROT_ERR); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        se;
        int          acc;
        apb_xfer(1'b1, 32'h30, 32'h0BADF00D, 4'd0, rd, se, acc);
        exp_cnt++;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'h30; PWDATA = 32'hFFFFFFFF; WAITS = 4'd4;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(posedge PCLK); #3;
        PRESETN = 1'b0;
        #1;
        $display("xfer reset mid-wait addr=00000030 cnt=%h prot_err=%0d", XFER_CNT, PROT_ERR);
        checks++; if (XFER_CNT !== 16'h0) begin errors++; $display("FAIL midrst_cnt: got %h want 0", XFER_CNT); end
        checks++; if (PROT_ERR !== 1'b0) begin errors++; $display("FAIL midrst_prot_err: got %b want 0", PROT_ERR); end
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL midrst_pready: got %b want 0", PREADY); end
        checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL midrst_pslverr: got %b want 0", PSLVERR); end
        checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL midrst_prdata: got %h want 0", PRDATA); end
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        // Setup presented together with reset release is taken on the next edge.
        PRESETN = 1'b1;
        exp_cnt = 16'h0;
        apb_xfer(1'b0, 32'h30, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (acc != 1) begin errors++; $display("FAIL postrst_len: got %0d want 1", acc); end
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL mem_preserved: got %h want 0badf00d", rd); end
        checks++; if (XFER_CNT !== 16'd1) begin errors++; $display("FAIL postrst_cnt: got %h want 0001", XFER_CNT); end
    endtask

    task automatic test_protocol();
        logic [31:0] rd;
        logic        se;
        int          acc;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
        PADDR = 32'h34; PWDATA = 32'h55555555; WAITS = 4'd0;
        @(posedge PCLK); #1;
        checks++; if (PROT_ERR !== 1'b1) begin errors++; $display("FAIL nosetup_prot_err: got %b want 1", PROT_ERR); end
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL nosetup_pready: got %b want 0", PREADY); end
        @(posedge PCLK); #1;
        checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL nosetup_stays_idle: got %b want 0", PREADY); end
        checks++; if (XFER_CNT !== exp_cnt) begin errors++; $display("FAIL nosetup_cnt: got %h want %h", XFER_CNT, exp_cnt); end
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("xfer access-without-setup addr=00000034 prot_err=%0d", PROT_ERR);
        apb_xfer(1'b0, 32'h34, 32'h0, 4'd0, rd, se, acc);
        exp_cnt++;
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL nosetup_no_write: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_capture();
        test_errors();
        test_back_to_back();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
